// File: rtl/sp_ram_loader.sv
// Streams words over a valid/ready handshake into a single-port RAM in address order,
// with a registered read port that is live in every state.
module sp_ram_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    hs;

    // in_ready is only high in LOAD, so it doubles as the state qualifier here
    always_comb begin
        hs = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        wr_ptr   <= '0;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                        if (wr_ptr == '1) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // RAM is never cleared; a write coinciding with reset is suppressed
    always_ff @(posedge clk) begin
        if (rst_n && hs) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_sp_ram_loader.sv
// Randomised and directed bench for sp_ram_loader against a cycle-level behavioural model.
module tb_sp_ram_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;

    int checks = 0;
    int failures = 0;

    // model: phase 0=idle 1=loading 2=complete
    int         mphase = 0;
    int         mptr = 0;
    int         mcnt = 0;
    logic [7:0] mmem [8];
    bit         known [8];
    logic [7:0] rd_exp;
    bit         rd_known;

    logic [7:0] pat [8] = '{8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hE7, 8'h18, 8'hB7, 8'hED};
    logic [7:0] fresh [8];

    always #5 clk = ~clk;

    sp_ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .busy(busy), .done(done),
        .count(count), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: advance model with the inputs present at the edge, then compare
    task automatic step();
        @(posedge clk);
        rd_exp   = mmem[rd_addr];
        rd_known = known[rd_addr];
        if (!rst_n) begin
            mphase = 0; mptr = 0; mcnt = 0;
            rd_exp = 8'h00; rd_known = 1'b1;
        end else if (mphase == 1) begin
            if (in_valid) begin
                mmem[mptr]  = in_data;
                known[mptr] = 1'b1;
                mcnt++;
                if (mptr == 7) mphase = 2;
                mptr = (mptr + 1) % 8;
            end
        end else if (start) begin
            mphase = 1; mptr = 0; mcnt = 0;
        end
        #1;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, mphase == 1});
        check_eq("busy", {31'd0, busy}, {31'd0, mphase == 1});
        check_eq("done", {31'd0, done}, {31'd0, mphase == 2});
        check_eq("count", {28'd0, count}, mcnt);
        if (rd_known) check_eq("rd_data", {24'd0, rd_data}, {24'd0, rd_exp});
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] d);
        in_valid = 1'b1; in_data = d; step(); in_valid = 1'b0;
    endtask

    task automatic readback(input string tag, input logic [7:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); step();
            check_eq(tag, {24'd0, rd_data}, {24'd0, exp[i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 8; i++) begin mmem[i] = 8'h00; known[i] = 1'b0; end
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_addr = 3'd0;

        // 1: reset
        step(); step();
        check_eq("t1_rd", {24'd0, rd_data}, 32'd0);
        check_eq("t1_count", {28'd0, count}, 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h55; step(); in_valid = 1'b0;  // ignored in IDLE
        check_eq("t1_idle_count", {28'd0, count}, 32'd0);

        // 2: back-to-back stream
        pulse_start();
        check_eq("t2_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = pat[i]; step();
        end
        in_valid = 1'b0;
        check_eq("t2_done", {31'd0, done}, 32'd1);
        check_eq("t2_count", {28'd0, count}, 32'd8);
        check_eq("t2_ready_lo", {31'd0, in_ready}, 32'd0);
        readback("t2_rd", pat);

        // 3: valid every other cycle
        pulse_start();
        cyc = 0;
        for (int k = 0; k < 40 && done !== 1'b1; k++) begin
            in_valid = (k % 2 == 1); in_data = pat[k / 2]; step(); cyc++;
        end
        in_valid = 1'b0;
        check_eq("t3_cycles", cyc, 32'd16);
        check_eq("t3_count", {28'd0, count}, 32'd8);
        readback("t3_rd", pat);

        // 4: read-during-write returns old word
        pulse_start();
        for (int i = 0; i < 8; i++) write_word(8'h3C);
        pulse_start();
        rd_addr = 3'd0; in_valid = 1'b1; in_data = 8'h5A; step(); in_valid = 1'b0;
        check_eq("t4_old", {24'd0, rd_data}, 32'h3C);
        step();
        check_eq("t4_new", {24'd0, rd_data}, 32'h5A);

        // 5: reset mid-load, then fresh load
        for (int i = 0; i < 3; i++) write_word(8'($urandom));
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check_eq("t5_count", {28'd0, count}, 32'd0);
        check_eq("t5_ready", {31'd0, in_ready}, 32'd0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin fresh[i] = 8'($urandom); write_word(fresh[i]); end
        readback("t5_rd", fresh);

        // 6: start ignored mid-load, honoured in DONE
        pulse_start();
        for (int i = 0; i < 3; i++) write_word(8'hFF);
        start = 1'b1; write_word(8'hFF); start = 1'b0;
        check_eq("t6_count_mid", {28'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) write_word(8'hFF);
        check_eq("t6_done", {31'd0, done}, 32'd1);
        pulse_start();
        check_eq("t6_restart_count", {28'd0, count}, 32'd0);
        check_eq("t6_restart_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) fresh[i] = 8'h00;
        for (int i = 0; i < 8; i++) write_word(8'h00);
        readback("t6_rd", fresh);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            start    = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 8'($urandom);
            rd_addr  = 3'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
